// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - external RAM request/acknowledge bus between mem_ctrl and the memory
interface mem_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MAR/MDR/IR owner running strobed RAM accesses over req/ack (optional MEMCTRL_TIMEOUT_EN)
module mem_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MAR_LOAD,
    input  logic          IR_LOAD,
    input  logic          MDR_LOAD,
    input  logic          RAM_LOAD,
    input  logic          BE,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] wdata,
    output logic [AW-1:0] mar,
    output logic [DW-1:0] mdr,
    output logic [DW-1:0] ir,
    output logic          busy,
    output logic          done,
    output logic          err,
    mem_ctrl_if.master    mem
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        r_state;
    logic [AW-1:0] r_mar;
    logic [DW-1:0] r_mdr;
    logic [DW-1:0] r_ir;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_mem_be;
    logic          r_tgt_ir;
    logic          r_tgt_mdr;
    logic          r_byte;
    logic          r_lane_hi;

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tmo_cnt;
`endif

    logic          w_any_rd;
    logic          w_start;
    logic [AW-1:0] w_eff_addr;
    logic          w_byte;
    logic [1:0]    w_be;
    logic [7:0]    w_lane;

    // Decode the incoming strobes; IR reads are always word-wide, writes honour BE.
    always_comb begin
        w_any_rd   = IR_LOAD | MDR_LOAD;
        w_start    = w_any_rd | RAM_LOAD;
        w_eff_addr = MAR_LOAD ? addr_in : r_mar;
        w_byte     = RAM_LOAD ? BE : (BE & ~IR_LOAD);
        w_be       = w_byte ? (w_eff_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        w_lane     = r_lane_hi ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
    end

    // Access sequencer: latch the request in IDLE, hold the bus until ack, pulse done once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_ir        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= 2'b00;
            r_tgt_ir    <= 1'b0;
            r_tgt_mdr   <= 1'b0;
            r_byte      <= 1'b0;
            r_lane_hi   <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (MAR_LOAD) begin
                r_mar <= addr_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ACCESS;
                        r_busy      <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= RAM_LOAD;
                        r_mem_addr  <= {w_eff_addr[AW-1:1], 1'b0};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_byte ? {(DW/8){wdata[7:0]}} : wdata;
                        r_tgt_ir    <= IR_LOAD & ~RAM_LOAD;
                        r_tgt_mdr   <= MDR_LOAD & ~RAM_LOAD;
                        r_byte      <= w_byte;
                        r_lane_hi   <= w_eff_addr[0];
`ifdef MEMCTRL_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                        if (RAM_LOAD && w_any_rd) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_start) begin
                        r_err <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_tgt_ir) begin
                            r_ir <= mem.mem_rdata;
                        end
                        if (r_tgt_mdr) begin
                            r_mdr <= r_byte ? {{(DW-8){1'b0}}, w_lane} : mem.mem_rdata;
                        end
`ifdef MEMCTRL_TIMEOUT_EN
                    end else if (r_tmo_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_tgt_ir) begin
                            r_ir <= '1;
                        end
                        if (r_tgt_mdr) begin
                            r_mdr <= '1;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    if (w_start) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mar           = r_mar;
    assign mdr           = r_mdr;
    assign ir            = r_ir;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - vector table plus request scoreboard and RAM responder for mem_ctrl
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MAR_LOAD = 1'b0, IR_LOAD = 1'b0, MDR_LOAD = 1'b0, RAM_LOAD = 1'b0, BE = 1'b0;
    logic [15:0] addr_in = '0, wdata = '0;
    logic [15:0] mar, mdr, ir;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    bit ram_enable = 1'b1;

    mem_ctrl_if #(.AW(16), .DW(16)) u_if ();

    mem_ctrl #(.AW(16), .DW(16), .TIMEOUT(15)) u_dut (
        .clk(clk), .reset(reset),
        .MAR_LOAD(MAR_LOAD), .IR_LOAD(IR_LOAD), .MDR_LOAD(MDR_LOAD), .RAM_LOAD(RAM_LOAD), .BE(BE),
        .addr_in(addr_in), .wdata(wdata),
        .mar(mar), .mdr(mdr), .ir(ir), .busy(busy), .done(done), .err(err),
        .mem(u_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [15:0] addr; bit [1:0] be; bit we; bit [15:0] wdata; int lat; bit [15:0] rdata;
    } req_t;
    req_t exp_q[$];

    typedef struct {
        bit pre; bit [15:0] addr; bit ir; bit mdr; bit ram; bit be;
        bit [15:0] wdata; bit [15:0] rdata; int lat;
        bit [15:0] e_addr; bit [1:0] e_be; bit [15:0] e_wdata; bit [15:0] e_mdr; bit [15:0] e_ir;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // RAM model: compares each new request against the scoreboard, then acks after its latency.
    initial begin
        req_t r;
        u_if.mem_ack   = 1'b0;
        u_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ram_enable && u_if.mem_req && !u_if.mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", {16'h0, u_if.mem_addr}, 32'hFFFF_FFFF);
                    u_if.mem_ack = 1'b1;
                    @(negedge clk);
                    u_if.mem_ack = 1'b0;
                end else begin
                    r = exp_q.pop_front();
                    check("mem_addr", {16'h0, u_if.mem_addr}, {16'h0, r.addr});
                    check("mem_be", {30'h0, u_if.mem_be}, {30'h0, r.be});
                    check("mem_we", {31'h0, u_if.mem_we}, {31'h0, r.we});
                    if (r.we) check("mem_wdata", {16'h0, u_if.mem_wdata}, {16'h0, r.wdata});
                    repeat (r.lat) @(negedge clk);
                    u_if.mem_rdata = r.rdata;
                    u_if.mem_ack   = 1'b1;
                    @(negedge clk);
                    u_if.mem_ack   = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input int exp_busy);
        int busy_cnt = 0;
        bit got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) got = 1;
        end
        check("done_seen", {31'h0, got}, 32'h1);
        if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
        @(negedge clk);
        check("done_once", {31'h0, done}, 32'h0);
        check("busy_clear", {31'h0, busy}, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mar"}, {16'h0, mar}, 32'h0);
        check({tag, "_mdr"}, {16'h0, mdr}, 32'h0);
        check({tag, "_ir"}, {16'h0, ir}, 32'h0);
        check({tag, "_flags"}, {29'h0, busy, done, err}, 32'h0);
        check({tag, "_req_we"}, {30'h0, u_if.mem_req, u_if.mem_we}, 32'h0);
        check({tag, "_bus"}, {u_if.mem_addr, u_if.mem_wdata}, 32'h0);
        check({tag, "_be"}, {30'h0, u_if.mem_be}, 32'h0);
    endtask

    initial begin
        req_t r;
        //          pre addr     ir mdr ram be wdata    rdata    lat e_addr   e_be   e_wdata  e_mdr    e_ir
        vecs[0] = '{0, 16'h0010, 0, 1, 0, 0, 16'h0000, 16'hBEEF, 2, 16'h0010, 2'b11, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 16'h0021, 0, 0, 1, 1, 16'h12AB, 16'h0000, 1, 16'h0020, 2'b10, 16'hABAB, 16'hBEEF, 16'h0000};
        vecs[2] = '{1, 16'h0020, 0, 1, 0, 1, 16'h0000, 16'h5A3C, 0, 16'h0020, 2'b01, 16'h0000, 16'h003C, 16'h0000};
        vecs[3] = '{1, 16'h0031, 0, 1, 0, 1, 16'h0000, 16'h5A3C, 1, 16'h0030, 2'b10, 16'h0000, 16'h005A, 16'h0000};
        vecs[4] = '{1, 16'h0045, 1, 0, 0, 1, 16'h0000, 16'h1234, 0, 16'h0044, 2'b11, 16'h0000, 16'h005A, 16'h1234};
        vecs[5] = '{0, 16'h0100, 1, 1, 0, 0, 16'h0000, 16'hC0DE, 3, 16'h0100, 2'b11, 16'h0000, 16'hC0DE, 16'hC0DE};
        vecs[6] = '{0, 16'h0203, 0, 0, 1, 0, 16'h9876, 16'h0000, 0, 16'h0202, 2'b11, 16'h9876, 16'hC0DE, 16'hC0DE};
        vecs[7] = '{1, 16'h0300, 0, 0, 1, 1, 16'h1255, 16'h0000, 4, 16'h0300, 2'b01, 16'h5555, 16'hC0DE, 16'hC0DE};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].pre) begin
                MAR_LOAD = 1'b1; addr_in = vecs[i].addr;
                @(negedge clk);
                MAR_LOAD = 1'b0; addr_in = 16'hFFFF;
                check("mar_preload", {16'h0, mar}, {16'h0, vecs[i].addr});
            end else begin
                MAR_LOAD = 1'b1; addr_in = vecs[i].addr;
            end
            IR_LOAD = vecs[i].ir; MDR_LOAD = vecs[i].mdr; RAM_LOAD = vecs[i].ram;
            BE = vecs[i].be; wdata = vecs[i].wdata;
            exp_q.push_back('{vecs[i].e_addr, vecs[i].e_be, vecs[i].ram, vecs[i].e_wdata,
                              vecs[i].lat, vecs[i].rdata});
            @(negedge clk);
            MAR_LOAD = 0; IR_LOAD = 0; MDR_LOAD = 0; RAM_LOAD = 0; BE = 0; wdata = '0;
            wait_done(vecs[i].lat + 1);
            check("vec_mdr", {16'h0, mdr}, {16'h0, vecs[i].e_mdr});
            check("vec_ir", {16'h0, ir}, {16'h0, vecs[i].e_ir});
            check("vec_err", {31'h0, err}, 32'h0);
        end

        // Collision: write beats a simultaneous read, then a read strobe arrives mid-access.
        MAR_LOAD = 1; addr_in = 16'h0500; RAM_LOAD = 1; MDR_LOAD = 1; wdata = 16'h7777;
        r = '{16'h0500, 2'b11, 1'b1, 16'h7777, 2, 16'hDEAD};
        exp_q.push_back(r);
        @(negedge clk);
        MAR_LOAD = 0; RAM_LOAD = 0; MDR_LOAD = 0; IR_LOAD = 1;
        check("coll_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        IR_LOAD = 0;
        wait_done(-1);
        repeat (3) @(negedge clk);
        check("coll_q_empty", exp_q.size(), 0);
        check("coll_mdr", {16'h0, mdr}, 32'h0000_C0DE);
        check("coll_ir", {16'h0, ir}, 32'h0000_C0DE);
        check("coll_err", {31'h0, err}, 32'h1);

        // Reset mid-access: the late ack must not touch anything.
        MAR_LOAD = 1; addr_in = 16'h0600; MDR_LOAD = 1;
        r = '{16'h0600, 2'b11, 1'b0, 16'h0000, 3, 16'hAAAA};
        exp_q.push_back(r);
        @(negedge clk);
        MAR_LOAD = 0; MDR_LOAD = 0;
        check("rst_req_before", {31'h0, u_if.mem_req}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_req_drop", {31'h0, u_if.mem_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_all_zero("post_rst");

`ifdef MEMCTRL_TIMEOUT_EN
        begin
            int req_cycles = 0;
            bit ended = 0;
            ram_enable = 1'b0;
            IR_LOAD = 1;
            @(negedge clk);
            IR_LOAD = 0;
            for (int c = 0; c < 40 && !ended; c++) begin
                if (u_if.mem_req) req_cycles++;
                else ended = 1;
                if (!ended) @(negedge clk);
            end
            check("tmo_req_cycles", req_cycles, 15);
            check("tmo_done", {31'h0, done}, 32'h1);
            @(negedge clk);
            check("tmo_done_once", {31'h0, done}, 32'h0);
            check("tmo_ir", {16'h0, ir}, 32'h0000_FFFF);
            check("tmo_err", {31'h0, err}, 32'h1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
